// File: rtl/ecc_io_pkg.sv
// ecc_io_pkg: length modes, frame-length helper and FSM state types shared by the ECC serial front end.
package ecc_io_pkg;

    typedef enum logic [1:0] {LEN32, LEN64, LEN128, LEN256} len_mode_e;
    typedef enum logic [2:0] {LD_IDLE, LD_MODE1, LD_MODE0, LD_SHIFT, LD_HOLD} ld_state_e;
    typedef enum logic {S_IDLE, S_SEND} ser_state_e;

    function automatic logic mode_over(input len_mode_e m, input int unsigned max_bits);
        return (32'd32 << m) > max_bits;
    endfunction

    // Requested width clamped to the physical register width.
    function automatic int unsigned frame_len(input len_mode_e m, input int unsigned max_bits);
        return mode_over(m, max_bits) ? max_bits : (32'd32 << m);
    endfunction

endpackage

// File: rtl/ecc_bit_serializer.sv
// ecc_bit_serializer: captures a multi-lane result word and shifts it out MSB-first over N cycles.
module ecc_bit_serializer
    import ecc_io_pkg::*;
#(
    parameter int OUT_LANES = 2,
    parameter int MAX_BITS  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  len_mode_e                     i_mode,
    input  logic                          i_res_valid,
    output logic                          o_res_ready,
    input  logic [OUT_LANES*MAX_BITS-1:0] i_res,
    output logic                          o_out_valid,
    output logic [OUT_LANES-1:0]          o_out
);
    localparam int CW = $clog2(MAX_BITS);

    ser_state_e          state_q;
    logic [CW-1:0]       cnt_q;
    logic [MAX_BITS-1:0] word_q [OUT_LANES];

    assign o_res_ready = state_q == S_IDLE;
    assign o_out_valid = state_q == S_SEND;

    // Words are left-aligned on capture so the current bit is always the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int j = 0; j < OUT_LANES; j++) word_q[j] <= '0;
        end else if (state_q == S_IDLE) begin
            if (i_res_valid) begin
                state_q <= S_SEND;
                cnt_q   <= CW'(frame_len(i_mode, MAX_BITS) - 1);
                for (int j = 0; j < OUT_LANES; j++)
                    word_q[j] <= i_res[j*MAX_BITS +: MAX_BITS] << (MAX_BITS - frame_len(i_mode, MAX_BITS));
            end
        end else begin
            for (int j = 0; j < OUT_LANES; j++) word_q[j] <= word_q[j] << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= S_IDLE;
        end
    end

    for (genvar j = 0; j < OUT_LANES; j++) begin : g_out
        assign o_out[j] = o_out_valid & word_q[j][MAX_BITS-1];
    end

endmodule

// File: rtl/ecc_serial_io.sv
// ecc_serial_io: serial operand loader and result serializer for the ECC core.
// Define ECC_IO_ABORT_EN to let i_start abort and restart an in-progress frame.
module ecc_serial_io
    import ecc_io_pkg::*;
#(
    parameter int MAX_BITS  = 256,
    parameter int IN_LANES  = 6,
    parameter int OUT_LANES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_mode,
    input  logic [IN_LANES-1:0]           i_lane,
    output logic                          o_load_valid,
    input  logic                          i_load_ready,
    output logic [IN_LANES*MAX_BITS-1:0]  o_operands,
    output logic [1:0]                    o_len_mode,
    output logic                          o_mode_err,
    input  logic                          i_res_valid,
    output logic                          o_res_ready,
    input  logic [OUT_LANES*MAX_BITS-1:0] i_res,
    output logic                          o_out_valid,
    output logic [OUT_LANES-1:0]          o_out
);
    localparam int CW = $clog2(MAX_BITS);

    ld_state_e           state_q;
    logic                mode1_q;
    logic [CW-1:0]       cnt_q;
    logic [MAX_BITS-1:0] opr_q [IN_LANES];
    len_mode_e           len_q;
    logic                err_q;
    logic                valid_q;
    len_mode_e           mode_now;
    logic                restart;

    assign mode_now = len_mode_e'({mode1_q, i_mode});

`ifdef ECC_IO_ABORT_EN
    assign restart = i_start && state_q != LD_IDLE;
`else
    assign restart = i_start && state_q == LD_HOLD && i_load_ready;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            mode1_q <= 1'b0;
            cnt_q   <= '0;
            len_q   <= LEN32;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int k = 0; k < IN_LANES; k++) opr_q[k] <= '0;
        end else if (restart) begin
            state_q <= LD_MODE1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                LD_IDLE:  if (i_start) state_q <= LD_MODE1;
                LD_MODE1: begin
                    mode1_q <= i_mode;
                    state_q <= LD_MODE0;
                end
                LD_MODE0: begin
                    len_q   <= mode_now;
                    err_q   <= mode_over(mode_now, MAX_BITS);
                    cnt_q   <= CW'(frame_len(mode_now, MAX_BITS) - 1);
                    state_q <= LD_SHIFT;
                    for (int k = 0; k < IN_LANES; k++) opr_q[k] <= '0;
                end
                LD_SHIFT: begin
                    for (int k = 0; k < IN_LANES; k++) opr_q[k] <= {opr_q[k][MAX_BITS-2:0], i_lane[k]};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= LD_HOLD;
                        valid_q <= 1'b1;
                    end
                end
                LD_HOLD: if (i_load_ready) begin
                    state_q <= LD_IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < IN_LANES; k++) begin : g_opr
        assign o_operands[k*MAX_BITS +: MAX_BITS] = opr_q[k];
    end

    assign o_load_valid = valid_q;
    assign o_len_mode   = len_q;
    assign o_mode_err   = err_q;

    ecc_bit_serializer #(.OUT_LANES(OUT_LANES), .MAX_BITS(MAX_BITS)) u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (len_q),
        .i_res_valid(i_res_valid),
        .o_res_ready(o_res_ready),
        .i_res      (i_res),
        .o_out_valid(o_out_valid),
        .o_out      (o_out)
    );

endmodule

// File: tb/tb_ecc_serial_io.sv
// tb_ecc_serial_io: directed scoreboard bench for ecc_serial_io (256-bit and 64-bit instances).
module tb_ecc_serial_io;

    logic clk = 1'b0;
    logic rst;
    logic start, start64, i_mode, ready, res_valid;
    logic [5:0] i_lane;
    logic [511:0] res;
    logic lv, merr, rr, ov;
    logic [1535:0] ops;
    logic [1:0] lm, oo;
    logic lv64, merr64, rr64, ov64;
    logic [383:0] ops64;
    logic [1:0] lm64, oo64;
    logic [127:0] res64 = '0;

    int vecs = 0;
    int errs = 0;
    logic [255:0] w [6];
    logic [255:0] last [6];
    logic [255:0] ld_q [$];
    logic [1:0] sq [$];

    always #5 clk = ~clk;

    ecc_serial_io dut (
        .clk(clk), .rst(rst), .i_start(start), .i_mode(i_mode), .i_lane(i_lane),
        .o_load_valid(lv), .i_load_ready(ready), .o_operands(ops), .o_len_mode(lm),
        .o_mode_err(merr), .i_res_valid(res_valid), .o_res_ready(rr), .i_res(res),
        .o_out_valid(ov), .o_out(oo)
    );

    ecc_serial_io #(.MAX_BITS(64)) dut64 (
        .clk(clk), .rst(rst), .i_start(start64), .i_mode(i_mode), .i_lane(i_lane),
        .o_load_valid(lv64), .i_load_ready(ready), .o_operands(ops64), .o_len_mode(lm64),
        .o_mode_err(merr64), .i_res_valid(1'b0), .o_res_ready(rr64), .i_res(res64),
        .o_out_valid(ov64), .o_out(oo64)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 6; k++)
            for (int j = 0; j < 8; j++) w[k][j*32 +: 32] = $urandom;
    endtask

    task automatic push_expected(input int n);
        logic [255:0] one, mask;
        one = 256'd1;
        mask = (one << n) - 1;
        for (int k = 0; k < 6; k++) ld_q.push_back(w[k] & mask);
    endtask

    task automatic start_pulse(input bit sel64);
        @(negedge clk);
        if (sel64) start64 = 1'b1; else start = 1'b1;
    endtask

    task automatic body(input logic [1:0] m, input int n, input int abort_at, input bit sel64);
        @(negedge clk);
        start = 1'b0;
        start64 = 1'b0;
        i_mode = m[1];
        @(negedge clk);
        i_mode = m[0];
        for (int b = n - 1; b >= 0; b--) begin
            @(negedge clk);
            if (b == 0) chk("lv_early", sel64 ? lv64 : lv, 0);
            for (int k = 0; k < 6; k++) i_lane[k] = w[k][b];
            start = (b == abort_at);
`ifdef ECC_IO_ABORT_EN
            if (b == abort_at) return;
`endif
        end
    endtask

    task automatic check_load(input bit sel64, input string tag);
        logic [255:0] obs;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_lv"}, sel64 ? lv64 : lv, 1);
        for (int k = 0; k < 6; k++) begin
            if (ld_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 1, 0);
            end else begin
                last[k] = ld_q.pop_front();
                obs = sel64 ? 256'(ops64[k*64 +: 64]) : ops[k*256 +: 256];
                chk($sformatf("%s_lane%0d", tag, k), obs, last[k]);
            end
        end
    endtask

    task automatic handshake(input bit sel64, input string tag);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk({tag, "_lv_drop"}, sel64 ? lv64 : lv, 0);
    endtask

    initial begin
        logic seen_lv, seen_ov;
        logic [255:0] x, y;
        rst = 1'b0;
        start = 1'b0; start64 = 1'b0; i_mode = 1'b0; ready = 1'b0;
        res_valid = 1'b0; i_lane = '0; res = '0;
        repeat (2) @(negedge clk);
        chk("rst_lv", lv, 0);
        chk("rst_ops", ops[255:0], 0);
        chk("rst_lm", lm, 0);
        chk("rst_err", merr, 0);
        chk("rst_rr", rr, 1);
        chk("rst_ov", ov, 0);
        chk("rst_oo", oo, 0);
        rst = 1'b1;

        // 32-bit frame with junk above bit 31 that must not be captured
        fill_random();
        w[0][31:0] = 32'hDEADBEEF; w[1][31:0] = 32'hCAFEBABE; w[2][31:0] = 32'h12345678;
        w[3][31:0] = 32'h0BADF00D; w[4][31:0] = 32'h80000001; w[5][31:0] = 32'hFFFFFFFF;
        push_expected(32);
        start_pulse(0);
        body(2'b00, 32, -1, 0);
        check_load(0, "m00");
        chk("m00_lm", lm, 0);
        chk("m00_err", merr, 0);
        handshake(0, "m00");
        chk("m00_stable_after_hs", ops[255:0], last[0]);

        // 256-bit frame held in HOLD while the core is not ready
        fill_random();
        push_expected(256);
        start_pulse(0);
        body(2'b11, 256, -1, 0);
        check_load(0, "m11");
        chk("m11_lm", lm, 3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("m11_hold_lv", lv, 1);
            chk("m11_hold_lane0", ops[255:0], last[0]);
            chk("m11_hold_lane5", ops[5*256 +: 256], last[5]);
        end
        handshake(0, "m11");

        // 128-bit request on a 64-bit instance clamps and flags
        fill_random();
        push_expected(64);
        start_pulse(1);
        body(2'b10, 64, -1, 1);
        check_load(1, "m64");
        chk("m64_err", merr64, 1);
        chk("m64_lm", lm64, 2);
        handshake(1, "m64");

        // i_start in the middle of SHIFT
        fill_random();
        start_pulse(0);
        body(2'b00, 32, 10, 0);
`ifdef ECC_IO_ABORT_EN
        fill_random();
        body(2'b00, 32, -1, 0);
`endif
        push_expected(32);
        check_load(0, "abort");
        chk("abort_lm", lm, 0);
        handshake(0, "abort");

        // result serialisation in 32-bit mode
        x = 256'h80000001;
        y = 256'h00000002;
        x[255:200] = '1;
        @(negedge clk);
        res = {y, x};
        res_valid = 1'b1;
        chk("ser_rr_idle", rr, 1);
        for (int b = 31; b >= 0; b--) sq.push_back({y[b], x[b]});
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            res_valid = 1'b0;
            if (c == 1) chk("ser_rr_busy", rr, 0);
            chk("ser_ov", ov, 1);
            if (sq.size() == 0) chk("ser_sb_empty", 1, 0);
            else chk($sformatf("ser_bit%0d", 31 - c), oo, sq.pop_front());
        end
        @(negedge clk);
        chk("ser_ov_end", ov, 0);
        chk("ser_sb_drained", sq.size(), 0);

        // reset during a 256-bit SHIFT and a 256-bit send
        fill_random();
        start_pulse(0);
        @(negedge clk); start = 1'b0; i_mode = 1'b1;
        @(negedge clk); i_mode = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            i_lane = 6'($urandom);
            res_valid = (c == 5);
            res = {w[1], w[0]};
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_lv", lv, 0);
        chk("mid_rst_ops0", ops[255:0], 0);
        chk("mid_rst_ops5", ops[5*256 +: 256], 0);
        chk("mid_rst_lm", lm, 0);
        chk("mid_rst_err", merr, 0);
        chk("mid_rst_rr", rr, 1);
        chk("mid_rst_ov", ov, 0);
        chk("mid_rst_oo", oo, 0);
        res_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen_lv = 1'b0;
        seen_ov = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            i_lane = 6'($urandom);
            seen_lv |= lv;
            seen_ov |= ov;
        end
        chk("post_rst_no_lv", seen_lv, 0);
        chk("post_rst_no_ov", seen_ov, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ecc_serial_io.md
# ecc_serial_io

Parametrised serial front end for the ECC scalar-multiply core. It deserialises a start-framed, MSB-first, multi-lane operand stream into parallel registers for the core. It also serialises the core's multi-word result back out MSB-first. It generalises the fixed 6-lane load / 2-lane unload protocol of the current wrapper to any lane count, any maximum width and length modes 32/64/128/256. It sits between the chip pads and the point-multiply datapath.

## Interface
Parameters:
- MAX_BITS, 256, maximum operand width; must be a power of two, at least 32.
- IN_LANES, 6, number of serial input lanes (a, b, prime, Px, Py, m by default).
- OUT_LANES, 2, number of serial output lanes (x, y).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle frame-start pulse.
- i_mode  in  1  serial length mode, MSB then LSB, on the two cycles after i_start.
- i_lane  in  IN_LANES  serial data, one bit per lane per cycle, MSB-first.
- o_load_valid  out  1  parallel operands available.
- i_load_ready  in  1  core accepts operands.
- o_operands  out  IN_LANES*MAX_BITS  lane k occupies bits [k*MAX_BITS +: MAX_BITS], right-aligned, upper bits zero.
- o_len_mode  out  2  latched length mode.
- o_mode_err  out  1  latched mode width exceeds MAX_BITS.
- i_res_valid  in  1  core result valid.
- o_res_ready  out  1  serializer idle.
- i_res  in  OUT_LANES*MAX_BITS  result, same packing as o_operands.
- o_out_valid  out  1  serial output active.
- o_out  out  OUT_LANES  serial result bits, MSB-first.

## Operation
Length rule:
- N = 32 << mode, where mode 00=32, 01=64, 10=128, 11=256.
- If N > MAX_BITS: set o_mode_err, clamp N to MAX_BITS and still run the frame.

Loader FSM:
- **IDLE**: on i_start, go to MODE1.
- **MODE1**: capture i_mode into mode[1]; go to MODE0.
- **MODE0**: capture i_mode into mode[0]; clear operand registers; load bit counter with N-1; go to SHIFT.
- **SHIFT**: each cycle, every lane register does reg = {reg[MAX_BITS-2:0], i_lane[k]}. The counter decrements; at 0 go to HOLD.
- **HOLD**: o_load_valid=1. Handshake completes on o_load_valid && i_load_ready; go to IDLE the next cycle.
  - o_operands and o_len_mode stay stable until the next frame reaches MODE0.
  - i_start in the handshake cycle is accepted and goes directly to MODE1.
- i_start outside IDLE and outside the handshake cycle: ignored, unless the Configuration macro says otherwise.
- i_mode and i_lane are don't-care outside their slots.

Serializer:
- In S_IDLE, o_res_ready=1.
- On i_res_valid && o_res_ready: capture i_res and the current o_len_mode (clamped N), then go to S_SEND.
- **S_SEND**: o_out_valid=1 for exactly N cycles. Lane j outputs bit N-1 down to bit 0 of its word. Then return to S_IDLE.
- Loader and serializer run concurrently and independently. A new frame may load while the previous result is still shifting out.

## Timing
- i_start sampled at edge T. Mode bits at T+1 and T+2. Data bits at T+3 .. T+N+2.
- o_load_valid rises after edge T+N+2, so it is visible in cycle T+N+3.
- Result: if i_res_valid is accepted at edge R, o_out_valid and the MSB appear in cycle R+1 and the last bit in cycle R+N.
- Reset values: o_load_valid=0, o_operands=0, o_len_mode=00, o_mode_err=0, o_res_ready=1, o_out_valid=0, o_out=0. Both FSMs go to idle.
- Reset asserted mid-frame or mid-send: the partial frame or result is discarded; nothing is emitted after release.

## Configuration
- ECC_IO_ABORT_EN defined: i_start in MODE1, MODE0, SHIFT or HOLD aborts the current frame and restarts at MODE1. o_load_valid drops the next cycle.
- ECC_IO_ABORT_EN undefined: i_start is ignored in those states.

## Structure
- Package ecc_io_pkg holds:
  - the mode typedef (2-bit enum LEN32/64/128/256);
  - a function for N from mode and MAX_BITS;
  - the loader and serializer state enums.
- Sub-module ecc_bit_serializer, parametrised by OUT_LANES and MAX_BITS, implements the serializer. The top-level block contains the loader.

## Test plan
- MAX_BITS=256, mode 00, lanes carrying 0xDEADBEEF etc. -> o_load_valid in cycle T+35; each lane's low 32 bits match its word; upper bits 0.
- mode 11, 256-bit pattern with ready held low for 10 cycles -> o_load_valid held high and operands stable for all 10 cycles; load completes on ready.
- MAX_BITS=64, mode 10 -> o_mode_err=1; 64 bits captured; o_load_valid in cycle T+67.
- Result with x=0x80000001, y=0x00000002 in 32-bit mode -> o_out_valid high for 32 cycles; first bits x=1, y=0; last bits x=1, y=0.
- i_start during SHIFT -> without macro: frame unaffected. With ECC_IO_ABORT_EN: restart; the new frame's data is captured.
- rst low mid-SHIFT and mid-send -> all outputs at reset values; no o_load_valid or o_out_valid after release.
